// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - op encodings and default parameters for the program counter with return-address stack
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD       = 3'd0,
    OP_NEXT       = 3'd1,
    OP_LOAD       = 3'd2,
    OP_BRANCH_REL = 3'd3,
    OP_CALL       = 3'd4,
    OP_RET        = 3'd5
  } op_e;

  localparam int DEF_WORD_SIZE    = 16;
  localparam int DEF_OFFSET_SIZE  = 8;
  localparam int DEF_RAS_DEPTH    = 4;
  localparam int DEF_RESET_VECTOR = 0;
  localparam int DEF_INC          = 1;

endpackage

// File: rtl/pc_ras_stack.sv
// rtl/pc_ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_rd_ptr;

  // r_top is the next write slot; when full it also points at the oldest entry
  assign w_rd_ptr = r_top - PW'(1);
  assign pop_data = r_mem[w_rd_ptr];
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_top] <= push_data;
      r_top        <= r_top + PW'(1);
      if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
    end else if (pop && (r_count != '0)) begin
      r_top   <= w_rd_ptr;
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with next-pc mux, relative branches, call/return stack and sticky stack errors
module pc_ras
  import pc_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int OFFSET_SIZE  = DEF_OFFSET_SIZE,
  parameter int RAS_DEPTH    = DEF_RAS_DEPTH,
  parameter int RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int INC          = DEF_INC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic                         cond,
  input  logic [WORD_SIZE-1:0]         data_in,
  input  logic [OFFSET_SIZE-1:0]       offset,
  input  logic                         err_clr,
  output logic [WORD_SIZE-1:0]         pc_counter,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [WORD_SIZE-1:0] r_pc;
  logic                 r_err_ovf;
  logic                 r_err_unf;

  logic [WORD_SIZE-1:0] w_seq;
  logic [WORD_SIZE-1:0] w_off;
  logic [WORD_SIZE-1:0] w_next;
  logic [WORD_SIZE-1:0] w_pop_data;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;

  assign w_seq = r_pc + WORD_SIZE'(INC);
  assign w_off = {{(WORD_SIZE-OFFSET_SIZE){offset[OFFSET_SIZE-1]}}, offset};

  assign ras_full      = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty     = (ras_count == '0);
  assign pc_counter    = r_pc;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

  always_comb begin
    w_next    = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_NEXT:       w_next = w_seq;
        OP_LOAD:       w_next = data_in;
        OP_BRANCH_REL: w_next = cond ? (r_pc + w_off) : w_seq;
        OP_CALL: begin
          w_next    = data_in;
          w_push    = 1'b1;
          w_ovf_evt = ras_full;
        end
        OP_RET: begin
          if (ras_empty) begin
            w_next    = w_seq;
            w_unf_evt = 1'b1;
          end else begin
            w_next = w_pop_data;
            w_pop  = 1'b1;
          end
        end
        default: w_next = r_pc;
      endcase
    end
  end

  // err_clr acts even while stalled; a same-cycle error event keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= WORD_SIZE'(RESET_VECTOR);
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_pc      <= w_next;
      r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
      r_err_unf <= w_unf_evt | (r_err_unf & ~err_clr);
    end
  end

  pc_ras_stack #(
    .WIDTH (WORD_SIZE),
    .DEPTH (RAS_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_seq),
    .pop_data  (w_pop_data),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - directed self-checking bench for pc_ras
module tb_pc_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic        cond;
  logic [15:0] data_in;
  logic [7:0]  offset;
  logic        err_clr;
  logic [15:0] pc_counter;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        err_overflow;
  logic        err_underflow;

  int checks   = 0;
  int failures = 0;

  pc_ras dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .op            (op),
    .cond          (cond),
    .data_in       (data_in),
    .offset        (offset),
    .err_clr       (err_clr),
    .pc_counter    (pc_counter),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [15:0] d, input logic [7:0] off,
                      input logic c, input logic e, input logic clr);
    op = o; data_in = d; offset = off; cond = c; en = e; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; op = 3'd0; cond = 1'b0;
    data_in = '0; offset = '0; err_clr = 1'b0;
    #2;
    check("reset_pc", 32'(pc_counter), 32'h0);
    check("reset_count", 32'(ras_count), 32'd0);
    check("reset_empty_full", {30'd0, ras_empty, ras_full}, 32'b10);
    check("reset_errs", {30'd0, err_overflow, err_underflow}, 32'b00);
    @(posedge clk); #1;
    rst = 1'b1;

    step(3'd1, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("next_1", 32'(pc_counter), 32'h1);
    step(3'd1, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("next_2", 32'(pc_counter), 32'h2);
    step(3'd1, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("next_3", 32'(pc_counter), 32'h3);
    step(3'd0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("hold", 32'(pc_counter), 32'h3);
    step(3'd6, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("op6_hold", 32'(pc_counter), 32'h3);
    step(3'd7, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("op7_hold", 32'(pc_counter), 32'h3);

    #2 rst = 1'b0;
    #1 check("async_reset_pc", 32'(pc_counter), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(3'd1, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("first_edge_after_reset", 32'(pc_counter), 32'h1);

    step(3'd2, 16'h0010, 8'h0, 1'b0, 1'b1, 1'b0);
    check("load_0010", 32'(pc_counter), 32'h0010);
    step(3'd3, 16'h0, 8'hFE, 1'b1, 1'b1, 1'b0);
    check("branch_taken_neg", 32'(pc_counter), 32'h000E);
    step(3'd2, 16'h0010, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd3, 16'h0, 8'hFE, 1'b0, 1'b1, 1'b0);
    check("branch_not_taken", 32'(pc_counter), 32'h0011);
    step(3'd3, 16'h0, 8'h7F, 1'b1, 1'b1, 1'b0);
    check("branch_taken_pos", 32'(pc_counter), 32'h0090);
    step(3'd2, 16'hFFFF, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd1, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("next_wrap", 32'(pc_counter), 32'h0000);

    step(3'd2, 16'h0020, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd4, 16'h0100, 8'h0, 1'b0, 1'b1, 1'b0);
    check("call_pc", 32'(pc_counter), 32'h0100);
    check("call_count", 32'(ras_count), 32'd1);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("ret_pc", 32'(pc_counter), 32'h0021);
    check("ret_count", 32'(ras_count), 32'd0);

    step(3'd2, 16'h0001, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd4, 16'h0002, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd4, 16'h0003, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd4, 16'h0004, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd4, 16'h0005, 8'h0, 1'b0, 1'b1, 1'b0);
    check("four_calls_full_no_ovf", {29'd0, ras_count, err_overflow}, {29'd4, 1'b0} );
    step(3'd4, 16'h0050, 8'h0, 1'b0, 1'b1, 1'b0);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    check("ovf_full", 32'(ras_full), 32'd1);
    check("ovf_count", 32'(ras_count), 32'd4);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("lifo_ret_1", 32'(pc_counter), 32'h6);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("lifo_ret_2", 32'(pc_counter), 32'h5);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("lifo_ret_3", 32'(pc_counter), 32'h4);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("lifo_ret_4", 32'(pc_counter), 32'h3);
    check("drained_empty", 32'(ras_empty), 32'd1);
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    step(3'd2, 16'hABCD, 8'h0, 1'b0, 1'b0, 1'b1);
    check("clr_while_stalled_ovf", 32'(err_overflow), 32'd0);
    check("stall_keeps_pc", 32'(pc_counter), 32'h3);

    step(3'd2, 16'h0040, 8'h0, 1'b0, 1'b1, 1'b0);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("unf_pc", 32'(pc_counter), 32'h0041);
    check("unf_flag", 32'(err_underflow), 32'd1);
    check("unf_count", 32'(ras_count), 32'd0);
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    check("unf_clr_concurrent", 32'(err_underflow), 32'd1);
    check("unf_clr_concurrent_pc", 32'(pc_counter), 32'h0042);
    step(3'd0, 16'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    check("unf_clr_alone", 32'(err_underflow), 32'd0);

    step(3'd2, 16'h1234, 8'h0, 1'b0, 1'b0, 1'b0);
    check("stall_load", 32'(pc_counter), 32'h0042);
    step(3'd2, 16'h1234, 8'h0, 1'b0, 1'b1, 1'b0);
    check("load_after_stall", 32'(pc_counter), 32'h1234);

    step(3'd4, 16'h0200, 8'h0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_count", 32'(ras_count), 32'd1);
    #2 rst = 1'b0;
    #1 check("reset_clears_count", 32'(ras_count), 32'd0);
    check("reset_clears_pc", 32'(pc_counter), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(3'd5, 16'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    check("ret_after_reset_underflows", {16'd0, pc_counter}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
